gf163_mul_ctrl: RTL and testbench
=================================

Name: gf163_mul_ctrl

Overview:
- Sequencer for the 32-bit-digit systolic GF(2^163) multiplier array (6 PEs, 6 digits of 32 bits = 192-bit operand frame).
- Accepts operands a and b from a host as 32-bit word beats over a valid/ready stream.
- Issues digits, g and the ctr start pulse to the array, then aligns and captures the array's 6 product digits on ctro.
- Returns the product to the host as a 6-beat output stream, with a timeout error path.

Parameters:
- DIGITS, 32, digit width in bits.
- NDIG, 6, digits per operand (ceil(163/32)).
- G_POLY, 192'h0...0800000000000000000000000000000000000000C9, field polynomial x^163+x^7+x^6+x^3+1, zero-extended to 192 bits.
- MAX_WAIT, 64, maximum cycles from the last issued digit to arr_ctro before timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous reset, active-high (asserted = 1) despite the name.
- in_valid  in  1  host operand beat valid.
- in_ready  out  1  controller accepts a beat.
- in_a  in  DIGITS  operand a digit.
- in_b  in  DIGITS  operand b digit.
- busy  out  1  high whenever state != IDLE.
- err  out  1  one-cycle pulse on timeout.
- arr_ctr  out  1  start pulse to array ctr.
- arr_a  out  DIGITS  digit to array a_in.
- arr_b  out  DIGITS  digit to array b_in.
- arr_g  out  DIGITS  digit to array g_in.
- arr_po  in  DIGITS  array product output po.
- arr_ctro  in  1  array ctro; marks the first valid po digit.
- out_valid  out  1  result beat valid.
- out_ready  in  1  host accepts a result beat.
- out_data  out  DIGITS  result digit.
- out_last  out  1  high on the final result beat.

Behaviour:
- Reset: state=IDLE; digit counter=0; wait counter=0; operand and result buffers cleared to 0.
- Reset values of outputs: in_ready=1, busy=0, err=0, arr_ctr=0, arr_a/arr_b/arr_g=0, out_valid=0, out_last=0, out_data=0.
- Reset overrides any in-flight operation; the partial operation is discarded and never reported.
- Digit order everywhere (input beats, array issue, array output, result beats) is most-significant digit first: beat k carries digit NDIG-1-k.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) stores the beat as digit NDIG-1, counter=1, and moves to LOAD.
- LOAD: in_ready=1. Each handshake stores the next lower digit. The beat that completes NDIG digits moves to ISSUE on the next cycle.
- ISSUE: lasts exactly NDIG consecutive cycles with no stalls. Cycle k drives arr_a/arr_b/arr_g with digit NDIG-1-k of a, b and G_POLY. arr_ctr=1 only in cycle 0. in_ready=0. Then moves to WAIT.
- Outside ISSUE, arr_a/arr_b/arr_g/arr_ctr are all driven to 0.
- WAIT: the wait counter increments each cycle. arr_ctro=1 captures arr_po as result digit NDIG-1 in the same cycle and moves to COLLECT. If the counter reaches MAX_WAIT with no ctro: err pulses for 1 cycle, buffers are cleared, and the state returns to IDLE.
- COLLECT: captures arr_po unconditionally on each of the next NDIG-1 cycles (ctro is not re-checked), then moves to DRAIN.
- DRAIN:
  - out_valid=1 and out_data=current result digit.
  - The beat advances only on out_valid & out_ready; out_data holds stable while out_ready=0.
  - out_last=1 on the NDIG-th beat.
  - The handshake of the last beat returns the state to IDLE, with in_ready=1 on the following cycle.
- No overlap between operations: in_ready=0 in ISSUE/WAIT/COLLECT/DRAIN. in_valid in those states is ignored and not stored.
- arr_ctro outside WAIT is ignored.
- The 192-bit result is reduced by the array. Bits 191:163 are passed through unmodified as produced by the array; the controller does not mask them.
- busy=1 from the first accepted beat until the cycle after the last result handshake or the err pulse.

Test Plan:
- a=1, b=1 (beats: five 0 words then 0x00000001 for both) with array model, out_ready=1 -> arr_ctr high exactly 1 cycle; 6 result beats 0,0,0,0,0,0x00000001; out_last on beat 6; busy returns to 0.
- a=x^162 (first beat 0x00000004, rest 0), b=x (last beat 0x00000002) -> result beats 0,0,0,0,0,0x000000C9.
- Same as the first scenario with out_ready toggling 1,0,0,1 -> out_data stable while stalled; exactly 6 handshakes; no beat duplicated or lost.
- in_valid held high with random words during ISSUE through DRAIN -> in_ready=0 throughout; the next operation starts only after return to IDLE and uses fresh operands.
- arr_ctro tied 0 -> err pulses exactly once, MAX_WAIT=64 cycles after the last ISSUE cycle; state=IDLE; out_valid never asserted.
- rstn asserted during ISSUE cycle 3 -> next cycle all outputs at reset values; a subsequent a=1, b=1 operation yields result 0x00000001 in the last beat.

Source files
------------

// File: rtl/gf163_mul_ctrl.sv
`default_nettype none
// gf163_mul_ctrl: stream sequencer for the 6-PE, 32-bit-digit systolic GF(2^163) multiplier.
// Operands, array issue, array capture and result beats all travel most-significant digit first.
module gf163_mul_ctrl #(
   parameter int                       DIGITS   = 32,
   parameter int                       NDIG     = 6,
   parameter logic [NDIG*DIGITS-1:0]   G_POLY   = 192'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9,
   parameter int                       MAX_WAIT = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIGITS-1:0] in_a,
   input  logic [DIGITS-1:0] in_b,
   output logic              busy,
   output logic              err,
   output logic              arr_ctr,
   output logic [DIGITS-1:0] arr_a,
   output logic [DIGITS-1:0] arr_b,
   output logic [DIGITS-1:0] arr_g,
   input  logic [DIGITS-1:0] arr_po,
   input  logic              arr_ctro,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DIGITS-1:0] out_data,
   output logic              out_last
);
   localparam int FRAME  = NDIG * DIGITS;
   localparam int CNT_W  = $clog2(NDIG + 1);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  LAST_DIG  = CNT_W'(NDIG - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_COLLECT = 3'd4,
      S_DRAIN   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   // All buffers are MSD-aligned shift registers: the active digit is always the top one.
   logic [FRAME-1:0]  a_q, a_d, b_q, b_d, g_q, g_d, r_q, r_d;

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wait_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         g_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         a_q     <= a_d;
         b_q     <= b_d;
         g_q     <= g_d;
         r_q     <= r_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wait_d    = wait_q;
      a_d       = a_q;
      b_d       = b_q;
      g_d       = g_q;
      r_d       = r_q;
      in_ready  = 1'b0;
      busy      = (state_q != S_IDLE);
      err       = 1'b0;
      arr_ctr   = 1'b0;
      arr_a     = '0;
      arr_b     = '0;
      arr_g     = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;

      case (state_q)
         S_IDLE, S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d = {a_q[FRAME-DIGITS-1:0], in_a};
               b_d = {b_q[FRAME-DIGITS-1:0], in_b};
               if (state_q == S_IDLE) begin
                  cnt_d   = CNT_W'(1);
                  state_d = S_LOAD;
               end else if (cnt_q == LAST_DIG) begin
                  cnt_d   = '0;
                  g_d     = G_POLY;
                  state_d = S_ISSUE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_ISSUE: begin
            arr_ctr = (cnt_q == '0);
            arr_a   = a_q[FRAME-1 -: DIGITS];
            arr_b   = b_q[FRAME-1 -: DIGITS];
            arr_g   = g_q[FRAME-1 -: DIGITS];
            a_d     = a_q << DIGITS;
            b_d     = b_q << DIGITS;
            g_d     = g_q << DIGITS;
            if (cnt_q == LAST_DIG) begin
               cnt_d   = '0;
               wait_d  = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_WAIT: begin
            // A ctro arriving in the final allowed cycle still wins over the timeout.
            if (arr_ctro) begin
               r_d     = {r_q[FRAME-DIGITS-1:0], arr_po};
               cnt_d   = CNT_W'(1);
               wait_d  = '0;
               state_d = S_COLLECT;
            end else if (wait_q == LAST_WAIT) begin
               err     = 1'b1;
               cnt_d   = '0;
               wait_d  = '0;
               a_d     = '0;
               b_d     = '0;
               g_d     = '0;
               r_d     = '0;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         S_COLLECT: begin
            r_d = {r_q[FRAME-DIGITS-1:0], arr_po};
            if (cnt_q == LAST_DIG) begin
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DRAIN: begin
            out_valid = 1'b1;
            out_data  = r_q[FRAME-1 -: DIGITS];
            out_last  = (cnt_q == LAST_DIG);
            if (out_ready) begin
               r_d = r_q << DIGITS;
               if (cnt_q == LAST_DIG) begin
                  cnt_d   = '0;
                  a_d     = '0;
                  b_d     = '0;
                  g_d     = '0;
                  r_d     = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            wait_d  = '0;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_gf163_mul_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_gf163_mul_ctrl: directed bench with a behavioural GF(2^163) array model and a result scoreboard.
module tb_gf163_mul_ctrl;
   localparam int NDIG = 6;
   localparam logic [191:0] G_REF = 192'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        busy, err, arr_ctr;
   logic [31:0] arr_a, arr_b, arr_g;
   logic [31:0] arr_po = '0;
   logic        arr_ctro = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   int           m_phase = 0;
   int           m_k = 0;
   int           m_cd = 0;
   int           m_lat = 2;
   bit           m_en = 1'b1;
   logic [191:0] m_a = '0, m_b = '0, m_p = '0, m_junk = '0;

   always #5 clk = ~clk;

   gf163_mul_ctrl dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .busy(busy), .err(err),
      .arr_ctr(arr_ctr), .arr_a(arr_a), .arr_b(arr_b), .arr_g(arr_g),
      .arr_po(arr_po), .arr_ctro(arr_ctro),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   // Bit-serial shift-and-add multiply with reduction by x^163 = x^7+x^6+x^3+1.
   function automatic logic [191:0] gf_mul(input logic [191:0] a, input logic [191:0] b);
      logic [162:0] r, x;
      r = '0;
      x = a[162:0];
      for (int i = 0; i < 163; i++) begin
         if (b[i]) r = r ^ x;
         if (x[162]) x = (x << 1) ^ 163'hC9;
         else        x = x << 1;
      end
      return {29'b0, r};
   endfunction

   // Array model: captures the six issued digits, then after m_lat cycles emits ctro with the product MSD first.
   always @(posedge clk) begin
      arr_ctro <= 1'b0;
      arr_po   <= '0;
      if (rstn) begin
         m_phase <= 0;
      end else begin
         case (m_phase)
            0: if (arr_ctr) begin
                  m_a     <= {arr_a, 160'b0};
                  m_b     <= {arr_b, 160'b0};
                  m_k     <= 1;
                  m_phase <= 1;
               end
            1: begin
                  m_a[191-32*m_k -: 32] <= arr_a;
                  m_b[191-32*m_k -: 32] <= arr_b;
                  m_k <= m_k + 1;
                  if (m_k == NDIG-1) begin
                     m_p     <= gf_mul({m_a[191:32], arr_a}, {m_b[191:32], arr_b}) ^ m_junk;
                     m_cd    <= m_lat;
                     m_phase <= m_en ? 2 : 0;
                  end
               end
            2: if (m_cd == 0) begin
                  arr_ctro <= 1'b1;
                  arr_po   <= m_p[191:160];
                  m_k      <= 1;
                  m_phase  <= 3;
               end else begin
                  m_cd <= m_cd - 1;
               end
            3: begin
                  arr_po <= m_p[191-32*m_k -: 32];
                  m_k    <= m_k + 1;
                  if (m_k == NDIG-1) m_phase <= 0;
               end
            default: m_phase <= 0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  in_ready,  1);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_err"},       err,       0);
      check({tag, "_arr_ctr"},   arr_ctr,   0);
      check({tag, "_arr_abg"},   arr_a | arr_b | arr_g, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_last"},  out_last,  0);
      check({tag, "_out_data"},  out_data,  0);
   endtask

   function automatic logic [191:0] rand163();
      logic [191:0] v;
      for (int k = 0; k < NDIG; k++) v[32*k +: 32] = $urandom;
      v[191:163] = '0;
      return v;
   endfunction

   task automatic send_op(input logic [191:0] a, input logic [191:0] b, input bit push);
      logic [191:0] p;
      if (push) begin
         p = gf_mul(a, b) ^ m_junk;
         for (int k = 0; k < NDIG; k++) exp_q.push_back(p[191-32*k -: 32]);
      end
      for (int k = 0; k < NDIG; k++) begin
         @(negedge clk);
         check("in_ready_load", in_ready, 1);
         in_valid = 1'b1;
         in_a     = a[191-32*k -: 32];
         in_b     = b[191-32*k -: 32];
      end
   endtask

   // pat=1 drives out_ready with the repeating 1,0,0,1 pattern; garbage keeps in_valid high with random words.
   task automatic collect(input bit pat, input bit garbage);
      int          beats;
      bit          stalled;
      logic [31:0] held;
      logic [3:0]  pbits;
      beats   = 0;
      stalled = 1'b0;
      held    = '0;
      pbits   = 4'b1001;
      for (int i = 0; i < 300 && beats < NDIG; i++) begin
         @(negedge clk);
         if (garbage) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            check("in_ready_busy", in_ready, 0);
         end else begin
            in_valid = 1'b0;
         end
         if (i < NDIG) begin
            check("arr_ctr_issue", arr_ctr, (i == 0) ? 1 : 0);
            check("arr_g_issue", arr_g, G_REF[191-32*i -: 32]);
         end else if (i == NDIG) begin
            check("arr_idle_after_issue", arr_ctr | arr_a | arr_b | arr_g, 0);
         end
         if (stalled) check("out_hold", out_data, held);
         out_ready = pat ? pbits[3 - (i % 4)] : 1'b1;
         stalled   = out_valid && !out_ready;
         held      = out_data;
         if (out_valid && out_ready) begin
            check("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
            check("out_last", out_last, (beats == NDIG-1) ? 1 : 0);
            beats++;
         end
      end
      in_valid  = 1'b0;
      check("beats_done", beats, NDIG);
      @(negedge clk);
      out_ready = 1'b1;
      check("post_busy", busy, 0);
      check("post_in_ready", in_ready, 1);
      check("post_out_valid", out_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [191:0] ra, rb;
      int err_n, err_at;
      bit ov;

      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rstn = 1'b0;

      m_lat = 2;
      send_op(192'h1, 192'h1, 1'b1);
      collect(1'b0, 1'b0);

      m_lat = 0;
      send_op({29'b0, 1'b1, 162'b0}, 192'h2, 1'b1);
      collect(1'b0, 1'b0);

      m_lat  = 5;
      m_junk = {32'hDEADBEE8, 160'b0};
      send_op(192'h1, 192'h1, 1'b1);
      collect(1'b1, 1'b0);
      m_junk = '0;

      m_lat = 3;
      send_op(rand163(), rand163(), 1'b1);
      collect(1'b0, 1'b1);
      ra = rand163();
      rb = rand163();
      send_op(ra, rb, 1'b1);
      collect(1'b1, 1'b0);

      m_en = 1'b0;
      send_op(rand163(), rand163(), 1'b0);
      err_n  = 0;
      err_at = -1;
      ov     = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (err) begin
            err_n++;
            err_at = i;
         end
         if (out_valid) ov = 1'b1;
      end
      check("err_pulses", err_n, 1);
      check("err_cycle", err_at, 69);
      check("timeout_no_out_valid", ov, 0);
      check("timeout_idle_busy", busy, 0);
      check("timeout_idle_ready", in_ready, 1);
      m_en = 1'b1;

      send_op(192'h1, 192'h1, 1'b0);
      repeat (4) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      check("issue3_busy", busy, 1);
      check("issue3_arr_b", arr_b, 0);
      rstn = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      rstn = 1'b0;
      m_lat = 1;
      send_op(192'h1, 192'h1, 1'b1);
      collect(1'b0, 1'b0);

      check("sb_empty_end", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
